// File: rtl/lottery_pkg.sv
// lottery_pkg: shared constants, FSM state encoding, result payload and
// ticket helpers for the lottery ticket arbiter.
package lottery_pkg;

  // Ticket geometry: five BCD digits packed LSB-first.
  localparam int unsigned DIGITS    = 5;
  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned TICKET_W  = 20;
  localparam int unsigned MAX_DIGIT = 9;
  localparam int unsigned DIG_IDX_W = 3;

  // Prize codes produced by the checker.
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    INSERT,
    GAP,
    FINISH,
    WAIT,
    REPORT
  } state_e;

  // Result returned to the owning console.
  typedef struct packed {
    logic [1:0] prize;
    logic       win;
    logic       err;
  } result_t;

  // Extract digit d (0 = first inserted) from a packed ticket.
  function automatic logic [DIGIT_W-1:0] get_digit(
    input logic [TICKET_W-1:0]  t,
    input logic [DIG_IDX_W-1:0] d
  );
    return DIGIT_W'(t >> (32'(d) * DIGIT_W));
  endfunction

  // A ticket is malformed if any digit is not valid BCD.
  function automatic logic ticket_bad(input logic [TICKET_W-1:0] t);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (get_digit(t, DIG_IDX_W'(i)) > DIGIT_W'(MAX_DIGIT)) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/lottery_ticket_arbiter_rr_arbiter.sv
// rr_arbiter: combinational N-way round-robin picker.
// Ports:
//   req_i    - per-console request vector
//   ptr_i    - index with highest priority this round
//   gnt_c    - one-hot grant (all zero when no request)
//   idx_c    - encoded index of the granted console
//   valid_c  - at least one request present
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             valid_c
);

  // Walk from the pointer upward with wrap; the first requester wins.
  always_comb begin
    int unsigned cand;
    gnt_c   = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(ptr_i) + k) % N_REQ;
      if (!valid_c && req_i[IDX_W'(cand)]) begin
        valid_c              = 1'b1;
        gnt_c[IDX_W'(cand)]  = 1'b1;
        idx_c                = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/lottery_ticket_arbiter.sv
// lottery_ticket_arbiter: shares one lottery checker between N_REQ consoles.
// A round-robin winner's ticket is latched, validated, replayed digit by
// digit into the checker, and the sampled result is returned with a
// one-cycle done strobe to the owner.
// Ports:
//   clk, reset            - clock, async active-high reset
//   req, ticket           - console requests and packed 20-bit tickets
//   gnt, done             - one-hot owner, one-cycle result strobe
//   prize, win, err, busy - result (qualified by done) and activity flag
//   chk_*                 - checker control (rst/insert/finish/num) and result
module lottery_ticket_arbiter
  import lottery_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned RESULT_WAIT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [TICKET_W*N_REQ-1:0] ticket,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [1:0]                prize,
  output logic                      win,
  output logic                      err,
  output logic                      busy,
  output logic                      chk_rst,
  output logic [3:0]                chk_num,
  output logic                      chk_insert,
  output logic                      chk_finish,
  input  logic [1:0]                chk_prize,
  input  logic                      chk_win
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(RESULT_WAIT + 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [TICKET_W-1:0]    tkt_q, tkt_d;
  logic [DIG_IDX_W-1:0]   dig_q, dig_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  logic [N_REQ-1:0]       done_q, done_d;
  result_t                res_q, res_d;
  logic                   busy_q, busy_d;
  logic                   chk_rst_q, chk_rst_d;
  logic                   chk_insert_q, chk_insert_d;
  logic                   chk_finish_q, chk_finish_d;
  logic [DIGIT_W-1:0]     chk_num_q, chk_num_d;

  logic [TICKET_W-1:0]    tickets [N_REQ];
  logic [N_REQ-1:0]       arb_gnt_c;
  logic [IDX_W-1:0]       arb_idx_c;
  logic                   arb_valid_c;

  // Unpack the flat ticket bus into per-console words.
  for (genvar i = 0; i < N_REQ; i++) begin : g_tkt
    assign tickets[i] = ticket[TICKET_W*i +: TICKET_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_c   (arb_gnt_c),
    .idx_c   (arb_idx_c),
    .valid_c (arb_valid_c)
  );

  // Next-state logic; outputs are decoded from the next state so they
  // register in lock-step with the state they belong to.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    tkt_d        = tkt_q;
    dig_d        = dig_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    res_d        = res_q;
    done_d       = '0;
    busy_d       = 1'b0;
    chk_rst_d    = 1'b0;
    chk_insert_d = 1'b0;
    chk_finish_d = 1'b0;
    chk_num_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid_c) begin
          gnt_d   = arb_gnt_c;
          owner_d = arb_idx_c;
          tkt_d   = tickets[arb_idx_c];
          // Malformed tickets skip the checker entirely.
          if (ticket_bad(tickets[arb_idx_c])) begin
            res_d   = '{prize: P0, win: 1'b0, err: 1'b1};
            state_d = REPORT;
          end else begin
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        dig_d   = '0;
        state_d = INSERT;
      end
      INSERT: begin
        state_d = GAP;
      end
      GAP: begin
        if (dig_q == DIG_IDX_W'(DIGITS - 1)) begin
          state_d = FINISH;
        end else begin
          dig_d   = dig_q + DIG_IDX_W'(1);
          state_d = INSERT;
        end
      end
      FINISH: begin
        cnt_d   = CNT_W'(RESULT_WAIT);
        state_d = WAIT;
      end
      WAIT: begin
        // Result is sampled on the edge that enters REPORT.
        if (cnt_q <= CNT_W'(1)) begin
          res_d   = '{prize: chk_prize, win: chk_win, err: 1'b0};
          state_d = REPORT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      REPORT: begin
        gnt_d   = '0;
        ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d       = (state_d != IDLE);
    chk_rst_d    = (state_d == CLEAR);
    chk_insert_d = (state_d == INSERT);
    chk_finish_d = (state_d == FINISH);
    if (state_d == INSERT) begin
      chk_num_d = get_digit(tkt_d, dig_d);
    end
    if (state_d == REPORT) begin
      done_d[owner_d] = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      tkt_q        <= '0;
      dig_q        <= '0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      res_q        <= '0;
      busy_q       <= 1'b0;
      chk_rst_q    <= 1'b0;
      chk_insert_q <= 1'b0;
      chk_finish_q <= 1'b0;
      chk_num_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      tkt_q        <= tkt_d;
      dig_q        <= dig_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      res_q        <= res_d;
      busy_q       <= busy_d;
      chk_rst_q    <= chk_rst_d;
      chk_insert_q <= chk_insert_d;
      chk_finish_q <= chk_finish_d;
      chk_num_q    <= chk_num_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign prize      = res_q.prize;
  assign win        = res_q.win;
  assign err        = res_q.err;
  assign busy       = busy_q;
  assign chk_rst    = chk_rst_q;
  assign chk_insert = chk_insert_q;
  assign chk_finish = chk_finish_q;
  assign chk_num    = chk_num_q;

endmodule
